// File: rtl/urv_dmem_responder_if.sv
// rtl/urv_dmem_responder_if.sv - uRV CPU data-memory bus bundle
//
// Purpose: groups the CPU data-interface signals between a uRV core (master)
// and a data-memory responder (slave).
// Signals:
//   dm_addr_i        [31:0] byte address           (master -> slave)
//   dm_data_s_i      [31:0] store data             (master -> slave)
//   dm_data_select_i [3:0]  byte-lane enables      (master -> slave)
//   dm_store_i              store request          (master -> slave)
//   dm_load_i               load request           (master -> slave)
//   dm_ready_o              request can be taken   (slave -> master)
//   dm_data_l_o      [31:0] load data              (slave -> master)
//   dm_load_done_o          load completion pulse  (slave -> master)
//   dm_store_done_o         store completion pulse (slave -> master)
//   dm_err_o                error pulse with done  (slave -> master)
interface urv_dmem_responder_if;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_store_i;
    logic        dm_load_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        dm_err_o;

    modport master (
        output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
        input  dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o, dm_err_o
    );

    modport slave (
        input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
        output dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o, dm_err_o
    );
endinterface

// File: rtl/urv_dmem_responder.sv
// rtl/urv_dmem_responder.sv - uRV data-memory slave with byte lanes and wait states
//
// Purpose: word-organised on-chip data RAM answering uRV load/store requests.
// The RAM is accessed on the acceptance edge; completion is reported
// g_wait_states cycles later through one-cycle done pulses.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset (RAM contents are kept)
//   bus    urv_dmem_responder_if.slave - CPU data interface
// Parameters:
//   g_addr_width   RAM depth is 2**g_addr_width 32-bit words
//   g_wait_states  extra cycles between acceptance and done (0..15)
module urv_dmem_responder #(
    parameter int g_addr_width  = 10,
    parameter int g_wait_states = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    urv_dmem_responder_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LP_CNT_INIT =
        (g_wait_states == 0) ? 4'd0 : 4'(g_wait_states - 1);
    localparam logic [32:0] LP_RANGE_LIMIT = 33'(1) << (g_addr_width + 2);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_load;     // pending completion is a load (else a store)
    logic        r_err;      // pending completion carries an error
    logic [31:0] r_hold;     // word read at acceptance, shown at load done
    logic [31:0] r_data_l;
    logic [31:0] r_ram [0:(1 << g_addr_width) - 1];

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_is_load;
    logic                    w_is_store;
    logic                    w_in_range;
    logic [g_addr_width-1:0] w_idx;
    logic [31:0]             w_rdata;

    assign w_ready    = (r_state != ST_WAIT);
    assign w_accept   = (bus.dm_load_i | bus.dm_store_i) & w_ready & ~rst_i;
    // A simultaneous load+store is handled as a store (flagged as an error).
    assign w_is_store = bus.dm_store_i;
    assign w_is_load  = bus.dm_load_i & ~bus.dm_store_i;
    // Comparing the whole address covers the "upper bits all zero" test.
    assign w_in_range = ({1'b0, bus.dm_addr_i} < LP_RANGE_LIMIT);
    assign w_idx      = bus.dm_addr_i[g_addr_width+1:2];
    assign w_rdata    = w_in_range ? r_ram[w_idx] : 32'd0;

    always_comb begin
        w_next              = r_state;
        bus.dm_ready_o      = w_ready;
        bus.dm_data_l_o     = r_data_l;
        bus.dm_load_done_o  = 1'b0;
        bus.dm_store_done_o = 1'b0;
        bus.dm_err_o        = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (r_state == ST_DONE) begin
                    bus.dm_load_done_o  = r_load;
                    bus.dm_store_done_o = ~r_load;
                    bus.dm_err_o        = r_err;
                end
                if (w_accept) begin
                    w_next = (g_wait_states == 0) ? ST_DONE : ST_WAIT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_load   <= 1'b0;
            r_err    <= 1'b0;
            r_hold   <= 32'd0;
            r_data_l <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt  <= LP_CNT_INIT;
                r_load <= w_is_load;
                r_err  <= ~w_in_range | (bus.dm_load_i & bus.dm_store_i);
                r_hold <= w_rdata;
                // Without wait states the done cycle is the very next one,
                // so the read word goes straight to the output register.
                if ((g_wait_states == 0) && w_is_load) begin
                    r_data_l <= w_rdata;
                end
            end else if (r_state == ST_WAIT) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else if (r_load) begin
                    r_data_l <= r_hold;
                end
            end
        end
    end

    // RAM write port: only selected lanes of an in-range accepted store.
    always_ff @(posedge clk_i) begin
        if (w_accept && w_is_store && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.dm_data_select_i[i]) begin
                    r_ram[w_idx][8*i +: 8] <= bus.dm_data_s_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_urv_dmem_responder.sv
// tb/tb_urv_dmem_responder.sv - self-checking bench for urv_dmem_responder
module tb_urv_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    urv_dmem_responder_if bus0 ();
    urv_dmem_responder_if bus3 ();

    urv_dmem_responder #(.g_addr_width(10), .g_wait_states(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0.slave));
    urv_dmem_responder #(.g_addr_width(10), .g_wait_states(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .bus(bus3.slave));

    logic [31:0] a_addr [2];
    logic [31:0] a_dat  [2];
    logic [3:0]  a_sel  [2];
    logic        a_ld   [2];
    logic        a_st   [2];
    logic        o_ready [2];
    logic [31:0] o_data  [2];
    logic        o_ldone [2];
    logic        o_sdone [2];
    logic        o_err   [2];

    assign bus0.dm_addr_i = a_addr[0];  assign bus3.dm_addr_i = a_addr[1];
    assign bus0.dm_data_s_i = a_dat[0]; assign bus3.dm_data_s_i = a_dat[1];
    assign bus0.dm_data_select_i = a_sel[0]; assign bus3.dm_data_select_i = a_sel[1];
    assign bus0.dm_load_i = a_ld[0];    assign bus3.dm_load_i = a_ld[1];
    assign bus0.dm_store_i = a_st[0];   assign bus3.dm_store_i = a_st[1];
    assign o_ready[0] = bus0.dm_ready_o;      assign o_ready[1] = bus3.dm_ready_o;
    assign o_data[0]  = bus0.dm_data_l_o;     assign o_data[1]  = bus3.dm_data_l_o;
    assign o_ldone[0] = bus0.dm_load_done_o;  assign o_ldone[1] = bus3.dm_load_done_o;
    assign o_sdone[0] = bus0.dm_store_done_o; assign o_sdone[1] = bus3.dm_store_done_o;
    assign o_err[0]   = bus0.dm_err_o;        assign o_err[1]   = bus3.dm_err_o;

    int npass = 0;
    int ntot  = 0;

    // Reference memory: one 1024-word array per DUT.
    logic [31:0] m_mem [2][1024];

    function automatic int wst(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Architectural effect of one request and the completion it must report.
    function automatic void model(input int d, input bit ld, input bit st,
                                  input logic [31:0] a, input logic [31:0] dat,
                                  input logic [3:0] sel, output bit eld,
                                  output bit est, output bit eerr,
                                  output logic [31:0] edata);
        bit inr;
        int idx;
        inr  = (a / 4096) == 0;
        idx  = (a / 4) % 1024;
        est  = st;
        eld  = ld && !st;
        eerr = !inr || (ld && st);
        if (st && inr)
            for (int i = 0; i < 4; i++)
                if (sel[i]) m_mem[d][idx][8*i +: 8] = dat[8*i +: 8];
        edata = (eld && inr) ? m_mem[d][idx] : 32'd0;
    endfunction

    // Issue one request at a negedge, wait for acceptance, then check the
    // wait-state window and the completion cycle. Returns at the done negedge.
    task automatic req(input int d, input bit ld, input bit st,
                       input logic [31:0] a, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] obs);
        bit eld, est, eerr;
        logic [31:0] ed;
        int g;
        a_addr[d] = a; a_dat[d] = dat; a_sel[d] = sel; a_ld[d] = ld; a_st[d] = st;
        g = 0;
        while (o_ready[d] !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        ntot++;
        if (g >= 20) $display("FAIL accept_timeout dut%0d: ready=%b required 1", d, o_ready[d]);
        else npass++;
        model(d, ld, st, a, dat, sel, eld, est, eerr, ed);
        @(negedge clk);
        a_ld[d] = 1'b0; a_st[d] = 1'b0;
        for (int i = 0; i < wst(d); i++) begin
            ntot++;
            if ({o_ready[d], o_ldone[d], o_sdone[d], o_err[d]} !== 4'b0000)
                $display("FAIL wait_window dut%0d cyc%0d: rdy/ld/st/err=%b required 0000",
                         d, i, {o_ready[d], o_ldone[d], o_sdone[d], o_err[d]});
            else npass++;
            @(negedge clk);
        end
        ntot++;
        if ({o_ready[d], o_ldone[d], o_sdone[d], o_err[d]} !== {1'b1, eld, est, eerr})
            $display("FAIL done_flags dut%0d addr=%h: rdy/ld/st/err=%b required %b", d, a,
                     {o_ready[d], o_ldone[d], o_sdone[d], o_err[d]}, {1'b1, eld, est, eerr});
        else npass++;
        if (eld) begin
            ntot++;
            if (o_data[d] !== ed)
                $display("FAIL load_data dut%0d addr=%h: got %h required %h", d, a, o_data[d], ed);
            else npass++;
        end
        obs = o_data[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if ({o_ready[d], o_ldone[d], o_sdone[d], o_err[d], o_data[d]} !== {4'b1000, 32'd0})
                $display("FAIL reset_state dut%0d: rdy/ld/st/err=%b data=%h required 1000 data 0",
                         d, {o_ready[d], o_ldone[d], o_sdone[d], o_err[d]}, o_data[d]);
            else npass++;
        end
    endtask

    task automatic test_basic();
        logic [31:0] obs;
        req(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, obs);
        req(0, 1, 0, 32'h10, 32'h0, 4'hF, obs);
        ntot++;
        if (obs !== 32'hDEADBEEF) $display("FAIL basic_load: got %h required deadbeef", obs);
        else npass++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] obs;
        req(0, 0, 1, 32'h20, 32'h11223344, 4'hF, obs);
        req(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, obs);
        req(0, 1, 0, 32'h22, 32'h0, 4'hF, obs);
        ntot++;
        if (obs !== 32'h11BB33DD) $display("FAIL byte_lanes: got %h required 11bb33dd", obs);
        else npass++;
    endtask

    task automatic test_wait_states();
        logic [31:0] obs, ea, eb;
        bit eld, est, eerr;
        req(1, 0, 1, 32'h40, 32'hCAFE0001, 4'hF, obs);
        req(1, 0, 1, 32'h44, 32'hCAFE0002, 4'hF, obs);
        a_addr[1] = 32'h40; a_ld[1] = 1'b1; a_st[1] = 1'b0;
        model(1, 1, 0, 32'h40, 32'h0, 4'hF, eld, est, eerr, ea);
        @(negedge clk);
        a_addr[1] = 32'h44;  // second load held while the responder is busy
        model(1, 1, 0, 32'h44, 32'h0, 4'hF, eld, est, eerr, eb);
        for (int i = 0; i < 3; i++) begin
            ntot++;
            if ({o_ready[1], o_ldone[1]} !== 2'b00)
                $display("FAIL ws_busy1 cyc%0d: rdy/ld=%b required 00", i, {o_ready[1], o_ldone[1]});
            else npass++;
            @(negedge clk);
        end
        ntot++;
        if ({o_ready[1], o_ldone[1], o_data[1]} !== {2'b11, ea})
            $display("FAIL ws_done1: rdy/ld=%b data=%h required 11 %h", {o_ready[1], o_ldone[1]}, o_data[1], ea);
        else npass++;
        @(negedge clk);
        a_ld[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ntot++;
            if ({o_ready[1], o_ldone[1], o_data[1]} !== {2'b00, ea})
                $display("FAIL ws_busy2 cyc%0d: rdy/ld=%b data=%h required 00 %h", i,
                         {o_ready[1], o_ldone[1]}, o_data[1], ea);
            else npass++;
            @(negedge clk);
        end
        ntot++;
        if ({o_ready[1], o_ldone[1], o_data[1]} !== {2'b11, eb})
            $display("FAIL ws_done2: rdy/ld=%b data=%h required 11 %h", {o_ready[1], o_ldone[1]}, o_data[1], eb);
        else npass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] obs;
        req(0, 0, 1, 32'h0, 32'h01020304, 4'hF, obs);
        req(0, 0, 1, 32'h00001000, 32'hFFFFFFFF, 4'hF, obs);
        req(0, 1, 0, 32'h00001000, 32'h0, 4'hF, obs);
        ntot++;
        if (obs !== 32'h0) $display("FAIL oor_load_data: got %h required 0", obs);
        else npass++;
        req(0, 1, 0, 32'h0, 32'h0, 4'hF, obs);
        ntot++;
        if (obs !== 32'h01020304) $display("FAIL oor_no_write: got %h required 01020304", obs);
        else npass++;
    endtask

    task automatic test_illegal();
        logic [31:0] obs;
        req(0, 1, 1, 32'h30, 32'h5, 4'hF, obs);
        req(0, 1, 0, 32'h30, 32'h0, 4'hF, obs);
        ntot++;
        if (obs !== 32'h5) $display("FAIL both_req_store: got %h required 5", obs);
        else npass++;
        req(0, 0, 1, 32'h30, 32'h12345678, 4'h0, obs);
        req(0, 1, 0, 32'h30, 32'h0, 4'hF, obs);
        ntot++;
        if (obs !== 32'h5) $display("FAIL sel0_no_write: got %h required 5", obs);
        else npass++;
    endtask

    task automatic test_back_to_back();
        bit eld, est, eerr, pend;
        logic [31:0] ed;
        pend = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (pend) begin
                ntot++;
                if ({o_ready[0], o_ldone[0], o_sdone[0], o_err[0]} !== {1'b1, eld, est, eerr} ||
                    (eld && o_data[0] !== ed))
                    $display("FAIL b2b cyc%0d: rdy/ld/st/err=%b data=%h required %b %h", c,
                             {o_ready[0], o_ldone[0], o_sdone[0], o_err[0]}, o_data[0],
                             {1'b1, eld, est, eerr}, ed);
                else npass++;
            end
            if (c < 8) begin
                a_addr[0] = 32'h80 + 32'(4 * (c / 2));
                a_dat[0]  = $urandom;
                a_sel[0]  = 4'(c % 2 == 0 ? 15 : 0);
                a_st[0]   = (c % 2 == 0);
                a_ld[0]   = (c % 2 == 1);
                model(0, a_ld[0], a_st[0], a_addr[0], a_dat[0], a_sel[0], eld, est, eerr, ed);
                pend = 1'b1;
            end
            @(negedge clk);
        end
        a_ld[0] = 1'b0; a_st[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs;
        a_addr[1] = 32'h40; a_ld[1] = 1'b1; a_st[1] = 1'b0;
        @(negedge clk);
        a_ld[1] = 1'b0;
        rst = 1'b1;  // lands in the first wait cycle
        @(negedge clk);
        rst = 1'b0;
        ntot++;
        if ({o_ready[1], o_ldone[1], o_sdone[1], o_data[1]} !== {3'b100, 32'd0})
            $display("FAIL mid_reset_state: rdy/ld/st=%b data=%h required 100 0",
                     {o_ready[1], o_ldone[1], o_sdone[1]}, o_data[1]);
        else npass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ntot++;
            if ({o_ldone[1], o_sdone[1]} !== 2'b00)
                $display("FAIL mid_reset_dropped cyc%0d: ld/st=%b required 00", i, {o_ldone[1], o_sdone[1]});
            else npass++;
        end
        req(1, 0, 1, 32'h48, 32'h600DF00D, 4'hF, obs);
        req(1, 1, 0, 32'h48, 32'h0, 4'hF, obs);
    endtask

    task automatic test_random(input int d);
        logic [31:0] obs, a;
        int kind;
        for (int k = 0; k < 8; k++) req(d, 0, 1, 32'h200 + 32'(4 * k), $urandom, 4'hF, obs);
        for (int n = 0; n < 30; n++) begin
            a = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = a | (($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h8000_0000);
            kind = $urandom_range(0, 3);
            req(d, kind != 1, kind == 1 || kind == 2, a, $urandom, 4'($urandom_range(0, 15)), obs);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            a_addr[d] = '0; a_dat[d] = '0; a_sel[d] = '0; a_ld[d] = 1'b0; a_st[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_byte_lanes();
        test_out_of_range();
        test_illegal();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
